// File: rtl/countdown_timer.sv
// countdown_timer: BCD M:SS countdown core (0:00 .. 9:59) feeding the 7-segment decoder stage.
// An internal prescaler derives a one-second tick from clk. An IDLE/RUN/PAUSE/DONE machine
// decrements the count once per tick down to 0:00 and pulses done when it gets there.
//
// Ports:
//   clk                       system clock, all logic on the rising edge
//   reset                     synchronous active-high reset, clears everything
//   clear                     clear count to 0:00, prescaler to 0, state to IDLE
//   load                      latch clamped loadMin/loadDsec/loadSec (ignored in RUN)
//   loadMin/loadDsec/loadSec  BCD preset digits
//   start / stop              begin-or-resume / pause counting (level or pulse)
//   min/dSec/sec              current count digits, registered
//   running                   registered, high while in RUN
//   zero                      combinational, high whenever the count is 0:00
//   done                      registered one-cycle pulse on counting down to 0:00
`timescale 1ns / 1ps

module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] loadMin,
  input  logic [3:0] loadDsec,
  input  logic [3:0] loadSec,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min,
  output logic [3:0] dSec,
  output logic [3:0] sec,
  output logic       running,
  output logic       zero,
  output logic       done
);

  localparam int unsigned PrescW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [3:0]        min_q, min_d;
  logic [3:0]        dsec_q, dsec_d;
  logic [3:0]        sec_q, sec_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic [3:0]        dec_min, dec_dsec, dec_sec;
  logic              dec_zero;
  logic              count_zero;
  logic              tick;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign count_zero = (min_q == 4'd0) && (dsec_q == 4'd0) && (sec_q == 4'd0);
  assign tick       = (presc_q == PrescLast);

  // One-second borrow chain. Never evaluated at 0:00 because RUN is left on reaching it.
  always_comb begin
    dec_min  = min_q;
    dec_dsec = dsec_q;
    dec_sec  = sec_q;
    if (sec_q != 4'd0) begin
      dec_sec = sec_q - 4'd1;
    end else begin
      dec_sec = 4'd9;
      if (dsec_q != 4'd0) begin
        dec_dsec = dsec_q - 4'd1;
      end else begin
        dec_dsec = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_min == 4'd0) && (dec_dsec == 4'd0) && (dec_sec == 4'd0);

  // Next-state: clear > load > stop > start; load in RUN is treated as absent.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    dsec_d  = dsec_q;
    sec_d   = sec_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = StIdle;
      presc_d = '0;
      min_d   = 4'd0;
      dsec_d  = 4'd0;
      sec_d   = 4'd0;
    end else if (load && (state_q != StRun)) begin
      state_d = StIdle;
      presc_d = '0;
      min_d   = clamp_digit(loadMin, 4'd9);
      dsec_d  = clamp_digit(loadDsec, 4'd5);
      sec_d   = clamp_digit(loadSec, 4'd9);
    end else begin
      unique case (state_q)
        StIdle, StPause: begin
          // Prescaler is left alone so a resume finishes the partial second.
          if (!stop && start && !count_zero) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d = '0;
            min_d   = dec_min;
            dsec_d  = dec_dsec;
            sec_d   = dec_sec;
            if (dec_zero) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      min_q     <= 4'd0;
      dsec_q    <= 4'd0;
      sec_q     <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      min_q     <= min_d;
      dsec_q    <= dsec_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign min     = min_q;
  assign dSec    = dsec_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign done    = done_q;
  assign zero    = count_zero;

endmodule
